// File: rtl/unsigned_mul_8x8_ha_array_reduce.sv
// Final reduction for the approximate 8x8 multipliers: weight-aligns the four
// HA-array rows and sums them into a 16-bit product through a two-stage pipeline.
module unsigned_mul_8x8_ha_array_reduce (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  ha_array_0_b,
  input  logic [8:0]  ha_array_0_t,
  input  logic [6:0]  ha_array_1_b,
  input  logic [8:0]  ha_array_1_t,
  input  logic [6:0]  ha_array_2_b,
  input  logic [8:0]  ha_array_2_t,
  input  logic [6:0]  ha_array_3_b,
  input  logic [8:0]  ha_array_3_t,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        ovf
);

  logic [6:0]  b_rows  [4];
  logic [8:0]  t_rows  [4];
  logic [16:0] row_val [4];

  assign b_rows[0] = ha_array_0_b;
  assign b_rows[1] = ha_array_1_b;
  assign b_rows[2] = ha_array_2_b;
  assign b_rows[3] = ha_array_3_b;
  assign t_rows[0] = ha_array_0_t;
  assign t_rows[1] = ha_array_1_t;
  assign t_rows[2] = ha_array_2_t;
  assign t_rows[3] = ha_array_3_t;

  // Row k sits at weight 4^k; its carry vector is one further column pair up.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
      assign row_val[gi] = (17'(t_rows[gi]) << (2 * gi))
                         + (17'(b_rows[gi]) << (2 * gi + 2));
    end
  endgenerate

  logic [12:0] p01_next;
  logic [16:0] p23_next;
  logic [16:0] sum_next;

  logic        s1_valid_reg;
  logic [12:0] s1_p01_reg;
  logic [16:0] s1_p23_reg;

  logic        s1_load;
  logic        s2_load;

  assign p01_next = row_val[0][12:0] + row_val[1][12:0];
  assign p23_next = row_val[2] + row_val[3];
  assign sum_next = 17'(s1_p01_reg) + s1_p23_reg;

  assign s2_load  = s1_valid_reg & (~out_valid | out_ready);
  assign in_ready = ~s1_valid_reg | s2_load;
  assign s1_load  = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_p01_reg   <= '0;
      s1_p23_reg   <= '0;
      out_valid    <= 1'b0;
      product      <= '0;
      ovf          <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid_reg <= 1'b1;
        s1_p01_reg   <= p01_next;
        s1_p23_reg   <= p23_next;
      end else if (s2_load) begin
        s1_valid_reg <= 1'b0;
      end

      // Output register only changes on advance, so a stalled result stays put.
      if (s2_load) begin
        out_valid <= 1'b1;
        product   <= sum_next[15:0];
        ovf       <= sum_next[16];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_array_reduce.sv
// Randomized and directed bench for the HA-array reduction stage, checked
// against a transaction-level model (weighted row sum plus an in-flight queue).
module tb_unsigned_mul_8x8_ha_array_reduce;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  b_in [4];
  logic [8:0]  t_in [4];
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        ovf;

  unsigned_mul_8x8_ha_array_reduce dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ha_array_0_b (b_in[0]),
    .ha_array_0_t (t_in[0]),
    .ha_array_1_b (b_in[1]),
    .ha_array_1_t (t_in[1]),
    .ha_array_2_b (b_in[2]),
    .ha_array_2_t (t_in[2]),
    .ha_array_3_b (b_in[3]),
    .ha_array_3_t (t_in[3]),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .ovf          (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] sum;
    int          load_edge;
  } item_t;

  item_t q[$];
  int    edge_cnt  = 0;
  int    checks    = 0;
  int    errors    = 0;
  int    n_acc     = 0;
  int    n_out     = 0;
  logic  seen_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Weighted sum of all eight operands, straight from the row definition.
  function automatic logic [16:0] ref_sum();
    int s = 0;
    int w = 1;
    for (int k = 0; k < 4; k++) begin
      s += int'(t_in[k]) * w + int'(b_in[k]) * w * 4;
      w *= 4;
    end
    return 17'(s);
  endfunction

  task automatic clear_rows();
    for (int k = 0; k < 4; k++) begin
      t_in[k] = '0;
      b_in[k] = '0;
    end
  endtask

  task automatic random_rows();
    for (int k = 0; k < 4; k++) begin
      t_in[k] = 9'($urandom);
      b_in[k] = 7'($urandom);
    end
  endtask

  // One clock cycle: compare mid-cycle, then advance the model at the edge.
  task automatic step();
    logic        exp_valid;
    logic        exp_ready;
    logic        acc;
    logic        pop;
    logic [16:0] new_sum;
    @(negedge clk);
    exp_valid = (q.size() > 0) && (q[0].load_edge < edge_cnt);
    exp_ready = (q.size() < 2) || out_ready;
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    if (exp_valid && out_valid) begin
      chk("product", 32'(product), 32'(q[0].sum[15:0]));
      chk("ovf", 32'(ovf), 32'(q[0].sum[16]));
    end
    seen_valid = out_valid;
    acc     = in_valid && exp_ready;
    pop     = exp_valid && out_ready;
    new_sum = ref_sum();
    @(posedge clk);
    edge_cnt++;
    if (pop) begin
      $display("out #%0d: product=0x%04h ovf=%0b", n_out, q[0].sum[15:0], q[0].sum[16]);
      n_out++;
      void'(q.pop_front());
    end
    if (acc) begin
      n_acc++;
      q.push_back('{sum: new_sum, load_edge: edge_cnt});
    end
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    edge_cnt++;
    q.delete();
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  // Push one row set through with out_ready high and pin the result to a literal.
  task automatic directed(input string name, input logic [15:0] exp_p, input logic exp_o);
    logic [16:0] m;
    int          n;
    m = ref_sum();
    chk({"model_", name}, 32'(m), {15'd0, exp_o, exp_p});
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    clear_rows();
    n = 0;
    seen_valid = 1'b0;
    while (!seen_valid && n < 6) begin
      step();
      n++;
    end
    if (!seen_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no out_valid, expected one within 6 cycles", name);
    end else begin
      chk({name, "_latency"}, 32'(n), 32'd2);
      chk({name, "_product"}, 32'(product), 32'(exp_p));
      chk({name, "_ovf"}, 32'(ovf), 32'(exp_o));
    end
  endtask

  initial begin
    int acc_before;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clear_rows();
    do_reset();

    clear_rows(); t_in[0] = 9'h1FF;
    directed("row0_t", 16'd511, 1'b0);
    clear_rows(); b_in[1] = 7'b0000001;
    directed("row1_b", 16'd16, 1'b0);
    clear_rows(); t_in[3] = 9'h001;
    directed("row3_t", 16'd64, 1'b0);
    for (int k = 0; k < 4; k++) begin
      t_in[k] = 9'h1FF;
      b_in[k] = 7'h7F;
    end
    directed("all_max", 16'h5257, 1'b1);

    // Backpressure: only two row sets fit while the output is stalled.
    acc_before = n_acc;
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      random_rows();
      step();
    end
    chk("stall_accepted", 32'(n_acc - acc_before), 32'd2);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("drain_empty", 32'(q.size()), 32'd0);

    // Reset with both stages full discards everything in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      random_rows();
      step();
    end
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Random traffic with random stalls on both sides.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      random_rows();
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("final_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
